mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WAIT_CYCLES, 2, memory access cycles per transfer; legal range 1..15
- BASE_ADDR, 1024, byte address of data-memory word 0
- DEPTH, 64, data-memory depth in 32-bit words
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on posedge
- rst, in, 1, asynchronous, active-low reset
- MEM_R_EN, in, 1, pipeline load request
- MEM_W_EN, in, 1, pipeline store request
- ALU_result, in, 32, byte address from the EX/MEM register
- ST_val, in, 32, store data
- freeze, out, 1, stalls the pipeline while high
- ready, out, 1, one-cycle pulse: transfer complete
- addr_error, out, 1, one-cycle pulse with ready: access rejected
- Mem_read_value, out, 32, registered load result
- mem_address, out, 32, word index to data memory
- mem_st_val, out, 32, write data to data memory
- mem_r_en, out, 1, data-memory read enable
- mem_w_en, out, 1, data-memory write enable
- mem_rdata, in, 32, combinational read data from data memory

Function
REQ-003 FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-004 Request SHALL be MEM_R_EN or MEM_W_EN sampled in IDLE; if both are high, the request SHALL be a write.
REQ-005 Word index SHALL be (ALU_result - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
REQ-006 Address SHALL be valid only if ALU_result >= BASE_ADDR, ALU_result[1:0] == 0, and word index < DEPTH.
REQ-007 IDLE with valid request: freeze=1 combinationally; latch word index, ST_val and op type; clear the counter; next state BUSY.
REQ-008 IDLE with invalid request: freeze=1; no memory enable asserted; next state DONE with error flag set.
REQ-009 IDLE with no request: freeze=0; memory outputs 0.
REQ-010 BUSY: freeze=1; mem_address and mem_st_val driven from the latched values; mem_r_en=1 in every BUSY cycle of a read; the counter increments each cycle.
REQ-011 BUSY last cycle (counter == WAIT_CYCLES-1): a write SHALL assert mem_w_en for this single cycle only; a read SHALL capture mem_rdata into Mem_read_value at the closing edge; next state DONE.
REQ-012 DONE: freeze=0; ready=1; addr_error=1 if the error flag is set; next state IDLE unconditionally, so no request is sampled in DONE.
REQ-013 Latency: a valid access SHALL hold freeze high for WAIT_CYCLES+1 cycles; ready SHALL follow in cycle WAIT_CYCLES+1. An invalid access SHALL hold freeze for 1 cycle and pulse ready in cycle 1.
REQ-014 Mem_read_value SHALL change only at the REQ-011 capture and SHALL hold its value otherwise, including across writes and errors.
REQ-015 mem_w_en and mem_r_en SHALL never be high in the same cycle.
REQ-016 Input changes during BUSY or DONE SHALL have no effect.

Reset
REQ-017 rst low SHALL immediately force state IDLE, counter 0, and error flag 0.
REQ-018 rst low SHALL drive all outputs to 0, including Mem_read_value, regardless of clk.
REQ-019 Reset asserted mid-BUSY SHALL abort the transfer with no further mem_w_en pulse; after release the block SHALL be idle and accept a new request.

Verification
REQ-020 Store then load, WAIT_CYCLES=2:
- Stimulus: MEM_W_EN, ALU_result=1028, ST_val=0xDEADBEEF.
- Response: mem_address=1; mem_w_en high in cycle 2 only; freeze high cycles 0-2; ready in cycle 3.
- Stimulus: load from 1028.
- Response: Mem_read_value=0xDEADBEEF at the ready cycle.
REQ-021 Invalid addresses:
- Stimulus: loads from 1026, 1020 and 1280 (word 64).
- Response: each gives freeze for 1 cycle, ready and addr_error together, no mem enable, and Mem_read_value unchanged.
REQ-022 Simultaneous enables:
- Stimulus: MEM_R_EN and MEM_W_EN both high at 1032.
- Response: write performed; mem_r_en stays 0.
REQ-023 Reset mid-operation:
- Stimulus: rst low during the first BUSY cycle of a store.
- Response: outputs 0 at once; no mem_w_en pulse; a following load completes normally.
REQ-024 Back-to-back and minimum latency:
- Stimulus: a request held continuously high.
- Response: exactly one transfer per IDLE-BUSY-DONE cycle, with a DONE gap of freeze=0 between transfers.
- Stimulus: repeat with WAIT_CYCLES=1.
- Response: freeze is 2 cycles.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Pipeline data-memory access controller: turns a one-shot load/store request into a
// multi-cycle memory transfer, stalling the pipeline and rejecting misaligned or out-of-range addresses.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned DEPTH       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic        freeze,
    output logic        ready,
    output logic        addr_error,
    output logic [31:0] Mem_read_value,
    output logic [31:0] mem_address,
    output logic [31:0] mem_st_val,
    output logic        mem_r_en,
    output logic        mem_w_en,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] BASE    = 32'(BASE_ADDR);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  LAST    = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Handshake: a request is a level on MEM_R_EN/MEM_W_EN seen in IDLE; the pipeline
    // must hold it while freeze is high, and ready pulses for exactly one cycle in DONE.
    state_t      state;
    logic [3:0]  cnt;
    logic        err_flag;
    logic        op_write;
    logic [31:0] idx_q;
    logic [31:0] data_q;

    logic        req;
    logic        addr_ok;
    logic [31:0] word_idx;

    assign req      = MEM_R_EN | MEM_W_EN;
    assign word_idx = (ALU_result - BASE) >> 2;
    assign addr_ok  = (ALU_result >= BASE) && (ALU_result[1:0] == 2'b00) && (word_idx < DEPTH_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            err_flag       <= 1'b0;
            op_write       <= 1'b0;
            idx_q          <= 32'd0;
            data_q         <= 32'd0;
            Mem_read_value <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (addr_ok) begin
                            idx_q    <= word_idx;
                            data_q   <= ST_val;
                            op_write <= MEM_W_EN;
                            cnt      <= 4'd0;
                            state    <= BUSY;
                        end else begin
                            err_flag <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        if (!op_write) begin
                            Mem_read_value <= mem_rdata;
                        end
                        state <= DONE;
                    end
                    cnt <= cnt + 4'd1;
                end
                DONE: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // freeze is combinational in IDLE so the requesting instruction stalls in its own cycle.
    always_comb begin
        freeze      = 1'b0;
        ready       = 1'b0;
        addr_error  = 1'b0;
        mem_address = 32'd0;
        mem_st_val  = 32'd0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        if (rst) begin
            case (state)
                IDLE: freeze = req;
                BUSY: begin
                    freeze      = 1'b1;
                    mem_address = idx_q;
                    mem_st_val  = data_q;
                    mem_r_en    = !op_write;
                    mem_w_en    = op_write && (cnt == LAST);
                end
                DONE: begin
                    ready      = 1'b1;
                    addr_error = err_flag;
                end
                default: freeze = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, randomized accesses against
// a transaction-level memory model, reset abort, back-to-back and WAIT_CYCLES=1 latency.
module tb_mem_access_ctrl;

    localparam int W  = 2;
    localparam int W1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_result, ST_val;
    logic        freeze, ready, addr_error, mem_r_en, mem_w_en;
    logic [31:0] Mem_read_value, mem_address, mem_st_val, mem_rdata;

    logic        r1;
    logic [31:0] alu1;
    logic        freeze1, ready1, addr_error1, mem_r_en1, mem_w_en1;
    logic [31:0] rv1, mem_address1, mem_st_val1, mem_rdata1;

    logic [31:0] dmem [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rv;
    logic [31:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(1024), .DEPTH(64)) u_dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_result(ALU_result), .ST_val(ST_val), .freeze(freeze), .ready(ready),
        .addr_error(addr_error), .Mem_read_value(Mem_read_value), .mem_address(mem_address),
        .mem_st_val(mem_st_val), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.WAIT_CYCLES(W1), .BASE_ADDR(1024), .DEPTH(64)) u_dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(1'b0),
        .ALU_result(alu1), .ST_val(32'd0), .freeze(freeze1), .ready(ready1),
        .addr_error(addr_error1), .Mem_read_value(rv1), .mem_address(mem_address1),
        .mem_st_val(mem_st_val1), .mem_r_en(mem_r_en1), .mem_w_en(mem_w_en1), .mem_rdata(mem_rdata1)
    );

    assign mem_rdata  = dmem[mem_address[5:0]];
    assign mem_rdata1 = 32'hCAFE_0000 | mem_address1;

    always @(posedge clk) begin
        if (mem_w_en) dmem[mem_address[5:0]] <= mem_st_val;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        valid;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = 32'd0; ST_val = 32'd0;
    endtask

    // Decode straight from the address rules, using division instead of shifts.
    task automatic model_decode(input logic [31:0] a, output logic v, output logic [31:0] wd);
        longint unsigned la;
        la = longint'(a);
        v  = (la >= 1024) && (la % 4 == 0) && ((la - 1024) / 4 < 64);
        wd = v ? 32'((la - 1024) / 4) : 32'd0;
    endtask

    // One transaction, started at a negedge; inputs are scrambled once it is in flight.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_valid, input logic [31:0] exp_word, input string tag);
        int rc = -1, fcnt = 0, wcnt = 0, rcnt = 0, wcyc = -1, both = 0, abad = 0, moved = 0;
        logic err_seen = 1'b0;
        logic [31:0] rv_at_ready = 32'd0;
        logic any;
        any = rd | wr;
        MEM_R_EN = rd; MEM_W_EN = wr; ALU_result = a; ST_val = d;
        if (any) begin
            if (exp_valid && !wr) exp_q.push_back(ref_mem[exp_word]);
            else exp_q.push_back(last_rv);
        end
        for (int c = 0; c < 40; c++) begin
            #1;
            if (freeze) fcnt++;
            if (mem_w_en) begin wcnt++; wcyc = c; end
            if (mem_r_en) rcnt++;
            if (mem_w_en && mem_r_en) both++;
            if ((mem_w_en || mem_r_en) && mem_address !== exp_word) abad++;
            if (mem_w_en && mem_st_val !== d) abad++;
            if (ready) begin
                rc = c; err_seen = addr_error; rv_at_ready = Mem_read_value;
                break;
            end
            if (Mem_read_value !== last_rv) moved++;
            if (!any) break;
            @(negedge clk);
            MEM_R_EN = 1'($urandom_range(0, 1)); MEM_W_EN = 1'($urandom_range(0, 1));
            ALU_result = $urandom; ST_val = $urandom;
        end
        if (!any) begin
            chk({tag, " idle_freeze"}, 32'(fcnt), 32'd0);
            chk({tag, " idle_en"}, 32'(wcnt + rcnt + abad), 32'd0);
        end else if (rc < 0) begin
            total++; bad++;
            $display("FAIL %s timeout: no ready within 40 cycles", tag);
            void'(exp_q.pop_front());
        end else begin
            chk({tag, " ready_cycle"}, 32'(rc), exp_valid ? 32'(W + 1) : 32'd1);
            chk({tag, " freeze_cycles"}, 32'(fcnt), exp_valid ? 32'(W + 1) : 32'd1);
            chk({tag, " addr_error"}, 32'(err_seen), 32'(!exp_valid));
            chk({tag, " w_en_count"}, 32'(wcnt), (exp_valid && wr) ? 32'd1 : 32'd0);
            if (exp_valid && wr) chk({tag, " w_en_cycle"}, 32'(wcyc), 32'(W));
            chk({tag, " r_en_count"}, 32'(rcnt), (exp_valid && !wr) ? 32'(W) : 32'd0);
            chk({tag, " en_overlap_or_addr"}, 32'(both + abad), 32'd0);
            chk({tag, " rv_stable"}, 32'(moved), 32'd0);
            chk({tag, " read_value"}, rv_at_ready, exp_q.pop_front());
            if (exp_valid && wr) ref_mem[exp_word] = d;
            if (exp_valid && !wr) last_rv = ref_mem[exp_word];
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        logic v;
        logic [31:0] wd, a;
        int cnt_r, mism;
        for (int i = 0; i < 64; i++) begin
            dmem[i]    = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        last_rv = 32'd0;
        r1 = 1'b1; alu1 = 32'd1024;
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; ALU_result = 32'd1028; ST_val = 32'h1;

        vecs[0]  = '{1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 1'b1, 32'd1};
        vecs[1]  = '{1'b1, 1'b0, 32'd1028, 32'h0,         1'b1, 32'd1};
        vecs[2]  = '{1'b1, 1'b0, 32'd1026, 32'h0,         1'b0, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'd1020, 32'h0,         1'b0, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'd1280, 32'h0,         1'b0, 32'd0};
        vecs[5]  = '{1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 1'b1, 32'd2};
        vecs[6]  = '{1'b1, 1'b0, 32'd1032, 32'h0,         1'b1, 32'd2};
        vecs[7]  = '{1'b0, 1'b1, 32'd1276, 32'h5A5A_5A5A, 1'b1, 32'd63};
        vecs[8]  = '{1'b1, 1'b0, 32'd1276, 32'h0,         1'b1, 32'd63};
        vecs[9]  = '{1'b0, 1'b1, 32'd1280, 32'h7777_7777, 1'b0, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 32'd1028, 32'h0,         1'b0, 32'd0};

        // Reset state with requests already asserted.
        #12;
        chk("reset_outs", {31'd0, freeze | ready | addr_error | mem_r_en | mem_w_en}, 32'd0);
        chk("reset_rv", Mem_read_value | mem_address | mem_st_val, 32'd0);
        chk("reset_outs1", {31'd0, freeze1 | ready1 | mem_w_en1 | mem_r_en1}, 32'd0);
        @(negedge clk);
        drive_idle(); r1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].valid, vecs[i].word,
                   $sformatf("vec%0d", i));
        end
        chk("vec_mem_word1", dmem[1], 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 32'd1024 + 4 * $urandom_range(0, 63);
                2: a = 32'd1024 + $urandom_range(0, 300);
                default: a = $urandom_range(0, 3000);
            endcase
            model_decode(a, v, wd);
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, v, wd,
                   $sformatf("rnd%0d", i));
        end

        // Reset during the first BUSY cycle of a store.
        MEM_W_EN = 1'b1; ALU_result = 32'd1040; ST_val = 32'h1111_2222;
        @(negedge clk);
        drive_idle();
        #1;
        chk("rst_busy_freeze", {31'd0, freeze}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_abort_outs", {27'd0, freeze, ready, addr_error, mem_r_en, mem_w_en}, 32'd0);
        chk("rst_abort_data", Mem_read_value | mem_address | mem_st_val, 32'd0);
        cnt_r = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (mem_w_en) cnt_r++;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (mem_w_en) cnt_r++;
            @(negedge clk);
        end
        chk("rst_no_wpulse", 32'(cnt_r), 32'd0);
        chk("rst_mem_kept", dmem[4], ref_mem[4]);
        last_rv = 32'd0;
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 32'd1, "post_rst_load");

        // Held request: IDLE-BUSY-BUSY-DONE repeating, freeze low only in DONE.
        MEM_R_EN = 1'b1; ALU_result = 32'd1024;
        cnt_r = 0; mism = 0;
        for (int c = 0; c < 4 * (W + 2); c++) begin
            #1;
            if (freeze !== ((c % (W + 2)) != W + 1)) mism++;
            if (ready !== ((c % (W + 2)) == W + 1)) mism++;
            if (ready) cnt_r++;
            @(negedge clk);
        end
        drive_idle();
        chk("b2b_pattern", 32'(mism), 32'd0);
        chk("b2b_transfers", 32'(cnt_r), 32'd4);
        chk("b2b_value", Mem_read_value, ref_mem[0]);

        // WAIT_CYCLES=1 instance: freeze two cycles per transfer.
        r1 = 1'b1; alu1 = 32'd1032;
        cnt_r = 0; mism = 0;
        for (int c = 0; c < 3 * (W1 + 2); c++) begin
            #1;
            if (freeze1 !== ((c % (W1 + 2)) != W1 + 1)) mism++;
            if (ready1 && addr_error1) mism++;
            if (ready1) cnt_r++;
            @(negedge clk);
        end
        r1 = 1'b0;
        chk("w1_pattern", 32'(mism), 32'd0);
        chk("w1_transfers", 32'(cnt_r), 32'd3);
        chk("w1_value", rv1, 32'hCAFE_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
